// File: rtl/relay_pkg.sv
// Shared constants for the relay framer: hi_simulate mode codes, modulation codes,
// FSM state encodings and the default start/end patterns.
package relay_pkg;

  localparam logic [2:0] MODE_SNIFFER        = 3'b100;
  localparam logic [2:0] MODE_FAKE_READER    = 3'b101;
  localparam logic [2:0] MODE_FAKE_TAG       = 3'b110;
  localparam logic [2:0] MODE_DEBUG_READBACK = 3'b111;

  localparam logic [2:0] MT_OFF         = 3'b000;
  localparam logic [2:0] MT_TAG_LISTEN  = 3'b001;
  localparam logic [2:0] MT_TAG_MOD     = 3'b010;
  localparam logic [2:0] MT_RDR_LISTEN  = 3'b011;
  localparam logic [2:0] MT_RDR_MOD     = 3'b100;
  localparam logic [2:0] MT_READBACK    = 3'b011;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LISTEN = 2'd1;
  localparam state_t ST_MOD    = 2'd2;

  localparam logic [19:0] DEF_RDR_START      = 20'h0000c;
  localparam logic [19:0] DEF_RDR_START_MASK = 20'hfffff;
  localparam logic [19:0] DEF_RDR_END1       = 20'h00000;
  localparam logic [19:0] DEF_RDR_END2       = 20'hc0000;
  localparam logic [19:0] DEF_RDR_END_MASK   = 20'hfffff;
  localparam logic [19:0] DEF_TAG_START      = 20'h000f0;
  localparam logic [19:0] DEF_TAG_START_MASK = 20'hfffff;
  localparam logic [19:0] DEF_TAG_END        = 20'h00000;
  localparam logic [19:0] DEF_TAG_END_MASK   = 20'h00fff;

  function automatic logic is_fake_mode(input logic [2:0] mode);
    return (mode == MODE_FAKE_READER) || (mode == MODE_FAKE_TAG);
  endfunction

endpackage

// File: rtl/relay_capture.sv
// Capture buffer for relay samples with a delayed, oldest-first serial readback.
module relay_capture
  import relay_pkg::*;
#(
  parameter int CAP_DEPTH  = 80,
  parameter int READ_DELAY = 524288
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sample,
  input  logic sample_en,
  input  logic cap_arm,
  input  logic read_en,
  output logic ssp_din,
  output logic cap_done
);

  localparam int CNT_W = $clog2(CAP_DEPTH + 1);
  localparam int DLY_W = (READ_DELAY < 1) ? 1 : $clog2(READ_DELAY + 1);

  logic [CAP_DEPTH-1:0] cap_buf;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_ptr;
  logic [DLY_W-1:0]     dly_cnt;

  // Arming wins over everything; readback only runs once the buffer is full and
  // after the delay has elapsed, then parks ssp_din high when the buffer is drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_buf  <= '0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      dly_cnt  <= '0;
      cap_done <= 1'b0;
      ssp_din  <= 1'b0;
    end else if (cap_arm) begin
      cap_buf  <= '0;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      dly_cnt  <= '0;
      cap_done <= 1'b0;
      ssp_din  <= 1'b0;
    end else begin
      if (strobe && sample_en && !cap_done) begin
        cap_buf[wr_cnt] <= sample;
        wr_cnt          <= wr_cnt + CNT_W'(1);
        if (wr_cnt == CNT_W'(CAP_DEPTH - 1)) begin
          cap_done <= 1'b1;
        end
      end

      if (!read_en) begin
        rd_ptr  <= '0;
        dly_cnt <= '0;
        ssp_din <= 1'b0;
      end else if (!cap_done) begin
        ssp_din <= 1'b0;
      end else if (strobe) begin
        if (dly_cnt != DLY_W'(READ_DELAY)) begin
          dly_cnt <= dly_cnt + DLY_W'(1);
          ssp_din <= 1'b0;
        end else if (rd_ptr != CNT_W'(CAP_DEPTH)) begin
          ssp_din <= cap_buf[rd_ptr];
          rd_ptr  <= rd_ptr + CNT_W'(1);
        end else begin
          ssp_din <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/relay_framer.sv
// Relay framer: samples the decoded relay stream, frames it by start/end patterns
// and selects the hi_simulate modulation type; capture/readback lives in relay_capture.
module relay_framer
  import relay_pkg::*;
#(
  parameter int DIV_W        = 4,
  parameter int SAMPLE_PHASE = 8,
  parameter int SHIFT_W      = 20,
  parameter int CHAR_W       = 8,
  parameter logic [SHIFT_W-1:0] RDR_START      = SHIFT_W'(DEF_RDR_START),
  parameter logic [SHIFT_W-1:0] RDR_START_MASK = SHIFT_W'(DEF_RDR_START_MASK),
  parameter logic [SHIFT_W-1:0] RDR_END1       = SHIFT_W'(DEF_RDR_END1),
  parameter logic [SHIFT_W-1:0] RDR_END2       = SHIFT_W'(DEF_RDR_END2),
  parameter logic [SHIFT_W-1:0] RDR_END_MASK   = SHIFT_W'(DEF_RDR_END_MASK),
  parameter logic [SHIFT_W-1:0] TAG_START      = SHIFT_W'(DEF_TAG_START),
  parameter logic [SHIFT_W-1:0] TAG_START_MASK = SHIFT_W'(DEF_TAG_START_MASK),
  parameter logic [SHIFT_W-1:0] TAG_END        = SHIFT_W'(DEF_TAG_END),
  parameter logic [SHIFT_W-1:0] TAG_END_MASK   = SHIFT_W'(DEF_TAG_END_MASK),
  parameter int OUT_TAP    = 3,
  parameter int CAP_DEPTH  = 80,
  parameter int READ_DELAY = 524288
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hi_simulate_mod_type,
  input  logic       bit_in,
  input  logic       tx_pending,
  input  logic       cap_arm,
  output logic [2:0] mod_type,
  output logic       data_out,
  output logic       ssp_din,
  output logic       cap_done,
  output logic       frame_active
);

  localparam int CNT_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

  logic [DIV_W-1:0]   divider;
  logic [SHIFT_W-1:0] shift_reg, shift_nxt, shifted;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt, cnt_inc;
  state_t             state, state_nxt;
  logic [2:0]         prev_mode;
  logic [2:0]         mod_type_nxt;
  logic               strobe, is_fake, is_reader, mode_change;
  logic               start_hit, end_hit;

  function automatic logic pattern_hit(input logic [SHIFT_W-1:0] value,
                                       input logic [SHIFT_W-1:0] pat,
                                       input logic [SHIFT_W-1:0] mask);
    return ((value ^ pat) & mask) == '0;
  endfunction

  assign strobe      = (divider == DIV_W'(SAMPLE_PHASE));
  assign is_fake     = is_fake_mode(hi_simulate_mod_type);
  assign is_reader   = (hi_simulate_mod_type == MODE_FAKE_READER);
  assign mode_change = (hi_simulate_mod_type != prev_mode);
  assign data_out    = shift_reg[OUT_TAP];

  // Patterns are judged on the value the shift register is about to take, so a
  // match and the resulting state change land on the same strobe.
  always_comb begin
    shifted = {shift_reg[SHIFT_W-2:0], bit_in};
    cnt_inc = (bit_cnt == CNT_W'(CHAR_W - 1)) ? '0 : bit_cnt + CNT_W'(1);
    if (is_reader) begin
      start_hit = pattern_hit(shifted, RDR_START, RDR_START_MASK);
      end_hit   = pattern_hit(shifted, RDR_END1, RDR_END_MASK) ||
                  pattern_hit(shifted, RDR_END2, RDR_END_MASK);
    end else begin
      start_hit = pattern_hit(shifted, TAG_START, TAG_START_MASK);
      end_hit   = pattern_hit(shifted, TAG_END, TAG_END_MASK);
    end

    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    state_nxt = state;
    if (mode_change) begin
      shift_nxt = '0;
      cnt_nxt   = '0;
      state_nxt = is_fake ? ST_LISTEN : ST_IDLE;
    end else if (is_fake && strobe) begin
      shift_nxt = shifted;
      cnt_nxt   = cnt_inc;
      if (start_hit && state != ST_IDLE) begin
        state_nxt = ST_MOD;
        cnt_nxt   = '0;
      end else if (state == ST_MOD && end_hit && cnt_inc == '0) begin
        state_nxt = ST_LISTEN;
      end
    end
  end

  always_comb begin
    mod_type_nxt = MT_OFF;
    if (hi_simulate_mod_type == MODE_DEBUG_READBACK) begin
      mod_type_nxt = MT_READBACK;
    end else if (state_nxt == ST_MOD) begin
      mod_type_nxt = is_reader ? MT_RDR_MOD : MT_TAG_MOD;
    end else if (state_nxt == ST_LISTEN) begin
      if (tx_pending) begin
        mod_type_nxt = MT_OFF;
      end else begin
        mod_type_nxt = is_reader ? MT_RDR_LISTEN : MT_TAG_LISTEN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divider      <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      state        <= ST_IDLE;
      prev_mode    <= 3'b000;
      mod_type     <= MT_OFF;
      frame_active <= 1'b0;
    end else begin
      divider      <= divider + DIV_W'(1);
      shift_reg    <= shift_nxt;
      bit_cnt      <= cnt_nxt;
      state        <= state_nxt;
      prev_mode    <= hi_simulate_mod_type;
      mod_type     <= mod_type_nxt;
      frame_active <= (state_nxt == ST_MOD);
    end
  end

  relay_capture #(
    .CAP_DEPTH (CAP_DEPTH),
    .READ_DELAY(READ_DELAY)
  ) u_capture (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .sample   (bit_in),
    .sample_en(is_fake),
    .cap_arm  (cap_arm),
    .read_en  (hi_simulate_mod_type == MODE_DEBUG_READBACK),
    .ssp_din  (ssp_din),
    .cap_done (cap_done)
  );

endmodule

// File: tb/tb_relay_framer.sv
// Bench for relay_framer: two instances (default masks, and a loose tag end mask that
// lets start and end match together) checked every cycle against a behavioural model.
module tb_relay_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       bit_in = 1'b0;
  logic       tx_pending = 1'b0;
  logic       cap_arm = 1'b0;

  logic [2:0] mt_a, mt_b;
  logic       do_a, do_b, ssp_a, ssp_b, done_a, done_b, fa_a, fa_b;

  int vecCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  relay_framer #(.READ_DELAY(4)) dut_a (
    .clk(clk), .reset(reset), .hi_simulate_mod_type(mode), .bit_in(bit_in),
    .tx_pending(tx_pending), .cap_arm(cap_arm), .mod_type(mt_a), .data_out(do_a),
    .ssp_din(ssp_a), .cap_done(done_a), .frame_active(fa_a)
  );

  relay_framer #(.READ_DELAY(4), .TAG_END_MASK(20'h0000f)) dut_b (
    .clk(clk), .reset(reset), .hi_simulate_mod_type(mode), .bit_in(bit_in),
    .tx_pending(tx_pending), .cap_arm(cap_arm), .mod_type(mt_b), .data_out(do_b),
    .ssp_din(ssp_b), .cap_done(done_b), .frame_active(fa_b)
  );

  // Model: phase 0 idle, 1 listen, 2 framing; 'since' counts samples since the
  // last alignment, 'rbk' counts readback strobes since the readback started.
  typedef struct packed {
    logic [1:0]  phase;
    logic [19:0] win;
    logic [15:0] since;
    logic [2:0]  prev;
    logic [3:0]  div;
    logic [2:0]  mt;
    logic        fa;
    logic [79:0] cbuf;
    logic [6:0]  wr;
    logic        done;
    logic [7:0]  rbk;
    logic        ssp;
  } model_t;

  model_t mA = '0;
  model_t mB = '0;

  function automatic model_t step(input model_t m, input logic [2:0] md, input logic b,
                                  input logic txp, input logic arm, input logic [19:0] tagEndMask);
    model_t n;
    logic strobe, fake, reader, startHit, endHit;
    logic [19:0] w;
    logic [15:0] s;
    n = m;
    strobe = (m.div == 4'd8);
    n.div = m.div + 4'd1;
    fake = (md == 3'b101) || (md == 3'b110);
    reader = (md == 3'b101);
    w = {m.win[18:0], b};
    s = m.since + 16'd1;
    startHit = reader ? (w == 20'h0000c) : (w == 20'h000f0);
    endHit = reader ? (w == 20'h00000 || w == 20'hc0000) : ((w & tagEndMask) == 20'h0);
    if (md != m.prev) begin
      n.prev = md;
      n.win = '0;
      n.since = '0;
      n.phase = fake ? 2'd1 : 2'd0;
    end else if (fake && strobe) begin
      n.win = w;
      n.since = s;
      if (startHit) begin
        n.phase = 2'd2;
        n.since = '0;
      end else if (m.phase == 2'd2 && endHit && s[2:0] == 3'd0) begin
        n.phase = 2'd1;
      end
    end
    if (md == 3'b111) n.mt = 3'b011;
    else if (n.phase == 2'd2) n.mt = reader ? 3'b100 : 3'b010;
    else if (n.phase == 2'd1) n.mt = txp ? 3'b000 : (reader ? 3'b011 : 3'b001);
    else n.mt = 3'b000;
    n.fa = (n.phase == 2'd2);
    if (arm) begin
      n.cbuf = '0;
      n.wr = '0;
      n.done = 1'b0;
      n.rbk = '0;
      n.ssp = 1'b0;
    end else begin
      if (strobe && fake && !m.done) begin
        n.cbuf[m.wr] = b;
        n.wr = m.wr + 7'd1;
        n.done = (m.wr == 7'd79);
      end
      if (md != 3'b111) begin
        n.rbk = '0;
        n.ssp = 1'b0;
      end else if (!m.done) begin
        n.ssp = 1'b0;
      end else if (strobe) begin
        if (m.rbk != 8'd255) n.rbk = m.rbk + 8'd1;
        if (n.rbk <= 8'd4) n.ssp = 1'b0;
        else if (n.rbk <= 8'd84) n.ssp = m.cbuf[n.rbk - 8'd5];
        else n.ssp = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mA <= '0;
      mB <= '0;
    end else begin
      mA <= step(mA, mode, bit_in, tx_pending, cap_arm, 20'h00fff);
      mB <= step(mB, mode, bit_in, tx_pending, cap_arm, 20'h0000f);
    end
  end

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("a_mod_type", mt_a, mA.mt);
    checkOutput("a_data_out", {2'b00, do_a}, {2'b00, mA.win[3]});
    checkOutput("a_ssp_din", {2'b00, ssp_a}, {2'b00, mA.ssp});
    checkOutput("a_cap_done", {2'b00, done_a}, {2'b00, mA.done});
    checkOutput("a_frame", {2'b00, fa_a}, {2'b00, mA.fa});
    checkOutput("b_mod_type", mt_b, mB.mt);
    checkOutput("b_data_out", {2'b00, do_b}, {2'b00, mB.win[3]});
    checkOutput("b_ssp_din", {2'b00, ssp_b}, {2'b00, mB.ssp});
    checkOutput("b_cap_done", {2'b00, done_b}, {2'b00, mB.done});
    checkOutput("b_frame", {2'b00, fa_b}, {2'b00, mB.fa});
  endtask

  task automatic tick();
    @(negedge clk);
    compareModel();
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [2:0] md, input logic b, input logic txp, input logic arm);
    mode = md;
    bit_in = b;
    tx_pending = txp;
    cap_arm = arm;
  endtask

  // Returns at the falling edge right after a sample strobe.
  task automatic waitStrobe();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (mA.div != 4'd9 && n < 40);
    if (mA.div != 4'd9) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL strobe_timeout: got no strobe, expected one within 40 cycles");
    end
  endtask

  task automatic sendBit(input logic b);
    bit_in = b;
    waitStrobe();
  endtask

  task automatic sendBits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
  endtask

  initial begin
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("rst_mod_type", mt_a, 3'b000);
    checkOutput("rst_data_out", {2'b00, do_a}, 3'b000);
    checkOutput("rst_ssp_din", {2'b00, ssp_a}, 3'b000);
    checkOutput("rst_cap_done", {2'b00, done_a}, 3'b000);
    checkOutput("rst_frame", {2'b00, fa_a}, 3'b000);
    reset = 1'b1;
    waitCycles(3);
    checkOutput("idle_mod_type", mt_a, 3'b000);
    waitStrobe();

    applyStimulus(3'b101, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("rdr_listen", mt_a, 3'b011);
    sendBits(32'h0, 16);
    sendBits(32'hc, 4);
    checkOutput("rdr_start", mt_a, 3'b100);
    checkOutput("rdr_frame", {2'b00, fa_a}, 3'b001);
    tx_pending = 1'b1;
    waitCycles(2);
    checkOutput("rdr_mod_txp", mt_a, 3'b100);
    tx_pending = 1'b0;
    sendBits(32'h0, 15);
    checkOutput("rdr_hold15", mt_a, 3'b100);
    sendBits(32'h0, 5);
    checkOutput("rdr_end", mt_a, 3'b011);
    tx_pending = 1'b1;
    waitCycles(2);
    checkOutput("listen_txp", mt_a, 3'b000);
    tx_pending = 1'b0;
    waitCycles(1);
    checkOutput("listen_txp_rel", mt_a, 3'b011);

    sendBits(32'hc, 4);
    checkOutput("rdr_restart", mt_a, 3'b100);
    checkOutput("rdr_data_out", {2'b00, do_a}, 3'b001);
    applyStimulus(3'b110, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("switch_mod_type", mt_a, 3'b001);
    checkOutput("switch_data_out", {2'b00, do_a}, 3'b000);
    checkOutput("switch_frame", {2'b00, fa_a}, 3'b000);

    sendBits(32'h0, 3);
    sendBits(32'hf0, 8);
    checkOutput("tag_start", mt_a, 3'b010);
    checkOutput("b_simul_start", {2'b00, fa_b}, 3'b001);
    sendBit(1'b1);
    sendBits(32'h0, 4);
    checkOutput("tag_hold5", mt_a, 3'b010);
    checkOutput("b_realigned", {2'b00, fa_b}, 3'b001);
    sendBits(32'h0, 8);
    checkOutput("tag_off_boundary", mt_a, 3'b010);
    checkOutput("b_end", {2'b00, fa_b}, 3'b000);
    sendBits(32'h0, 3);
    checkOutput("tag_end", mt_a, 3'b001);

    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    checkOutput("arm_done", {2'b00, done_a}, 3'b000);
    for (int i = 0; i < 80; i++) begin
      sendBit((i % 2) == 0);
      if (i == 78) checkOutput("cap_not_full", {2'b00, done_a}, 3'b000);
    end
    checkOutput("cap_full", {2'b00, done_a}, 3'b001);

    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rb_mod_type", mt_a, 3'b011);
    for (int i = 0; i < 87; i++) begin
      waitStrobe();
      if (i < 4) checkOutput("rb_delay", {2'b00, ssp_a}, 3'b000);
      else if (i < 84) checkOutput("rb_data", {2'b00, ssp_a}, {2'b00, ((i - 4) % 2) == 0});
      else checkOutput("rb_tail", {2'b00, ssp_a}, 3'b001);
    end
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    checkOutput("rb_abort_ssp", {2'b00, ssp_a}, 3'b000);
    checkOutput("rb_abort_done", {2'b00, done_a}, 3'b000);
    waitCycles(2);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("passive_mod_type", mt_a, 3'b000);

    applyStimulus(3'b101, 1'b0, 1'b0, 1'b0);
    sendBits(32'hc, 4);
    checkOutput("pre_rst_mod", mt_a, 3'b100);
    reset = 1'b0;
    #1;
    checkOutput("midrst_mod_type", mt_a, 3'b000);
    checkOutput("midrst_data_out", {2'b00, do_a}, 3'b000);
    checkOutput("midrst_ssp_din", {2'b00, ssp_a}, 3'b000);
    checkOutput("midrst_cap_done", {2'b00, done_a}, 3'b000);
    checkOutput("midrst_frame", {2'b00, fa_a}, 3'b000);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(3);
    checkOutput("post_rst_mod", mt_a, 3'b000);
    applyStimulus(3'b101, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("post_rst_listen", mt_a, 3'b011);
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
